// File: rtl/vga_pkg.sv
// Shared VGA definitions: default counter width and the reference 800x600 raster geometry,
// used by the generator, the recovery block and their benches.
package vga_pkg;

  // Default width for pixel/line counters and measurements.
  localparam int unsigned CW_DEFAULT = 11;

  // Reference 800x600 raster (totals include blanking).
  localparam int unsigned H_TOTAL  = 1056;
  localparam int unsigned V_TOTAL  = 628;
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

endpackage

// File: rtl/vga_edge_det.sv
// Registered falling-edge detector with sample enable.
// The history register only updates on cycles where en=1, so fall compares the current input
// against the value seen at the previous enabled cycle.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset (history cleared to 0)
//   en   in  sample enable
//   din  in  monitored signal
//   fall out en & history & ~din (combinational from din and history)
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic fall
);

  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else if (en) begin
      hist_q <= din;
    end
  end

  assign fall = en & hist_q & ~din;

endmodule

// File: rtl/vga_timing_recover.sv
// Sink-side VGA timing recovery. Regenerates hcount/vcount from incoming blanking signals,
// measures line length and lines per frame, and declares lock after LOCK_FRAMES consecutive
// equal frame-length comparisons. All outputs are registered and describe the previous cycle's
// input sample.
// Ports:
//   pclk, rst                          clock, async active-high reset
//   hsync_in/vsync_in/hblnk_in/vblnk_in incoming raster
//   hsync_o/vsync_o/hblnk_o/vblnk_o     inputs delayed one cycle
//   hcount/vcount                      recovered pixel/line index (0 = first active)
//   line_len/frame_lines               last measured line length / lines per frame
//   locked                             stable timing indication
//   timing_err                         one-cycle pulse on any consistency violation
module vga_timing_recover
  import vga_pkg::*;
#(
  parameter int unsigned CW          = CW_DEFAULT,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          hblnk_in,
  input  logic          vblnk_in,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          hblnk_o,
  output logic          vblnk_o,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] frame_lines,
  output logic          locked,
  output logic          timing_err
);

  localparam logic [CW-1:0]  CMAX     = '1;
  localparam int unsigned    LCW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCW-1:0] LOCK_TGT = LCW'(LOCK_FRAMES);

  logic ls, fs;

  // Line start: hblnk falling edge cycle to cycle.
  vga_edge_det u_hblnk_det (
    .clk  (pclk),
    .rst  (rst),
    .en   (1'b1),
    .din  (hblnk_in),
    .fall (ls)
  );

  // Frame start: vblnk falling between consecutive line starts (history sampled only at LS).
  vga_edge_det u_vblnk_det (
    .clk  (pclk),
    .rst  (rst),
    .en   (ls),
    .din  (vblnk_in),
    .fall (fs)
  );

  logic [CW-1:0]  hcount_d, vcount_d, line_len_d, frame_lines_d, ref_len_q, ref_len_d;
  logic [CW-1:0]  len_meas, lines_meas;
  logic           line_seen_q, line_seen_d, ref_valid_q, ref_valid_d;
  logic           frame_seen_q, frame_seen_d, flen_valid_q, flen_valid_d;
  logic           locked_d, err;
  logic           line_mis, frame_mis, sat_hit;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    len_meas   = (hcount == CMAX) ? CMAX : hcount + CW'(1);
    lines_meas = (vcount == CMAX) ? CMAX : vcount + CW'(1);

    line_mis  = ls & line_seen_q & ref_valid_q & (len_meas != ref_len_q);
    frame_mis = fs & frame_seen_q & flen_valid_q & (lines_meas != frame_lines);
    // Fires only on the step into saturation, so one pulse per episode; LS takes priority.
    sat_hit   = ~ls & (hcount == CMAX - CW'(1));
    err       = line_mis | frame_mis | sat_hit;

    hcount_d = ls ? '0 : len_meas;

    vcount_d = vcount;
    if (fs)      vcount_d = '0;
    else if (ls) vcount_d = lines_meas;

    line_len_d  = line_len;
    line_seen_d = err ? 1'b0 : line_seen_q;
    ref_len_d   = ref_len_q;
    ref_valid_d = ref_valid_q;
    if (ls) begin
      line_seen_d = 1'b1;
      if (line_seen_q) begin
        line_len_d = len_meas;
        if (!ref_valid_q) begin
          ref_len_d   = len_meas;
          ref_valid_d = 1'b1;
        end
      end
    end
    // The line ending at FS belongs to the old frame; the new frame picks a fresh reference.
    if (fs || err) ref_valid_d = 1'b0;

    frame_seen_d  = frame_seen_q | fs;
    frame_lines_d = frame_lines;
    flen_valid_d  = flen_valid_q;
    lock_cnt_d    = lock_cnt_q;
    if (fs && frame_seen_q) begin
      frame_lines_d = lines_meas;
      flen_valid_d  = 1'b1;
      if (flen_valid_q && !frame_mis && lock_cnt_q != LOCK_TGT) begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end
    if (err) begin
      lock_cnt_d   = '0;
      flen_valid_d = 1'b0;
    end

    locked_d = err ? 1'b0 : ((lock_cnt_d == LOCK_TGT) ? 1'b1 : locked);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hsync_o      <= 1'b0;
      vsync_o      <= 1'b0;
      hblnk_o      <= 1'b0;
      vblnk_o      <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      line_len     <= '0;
      frame_lines  <= '0;
      locked       <= 1'b0;
      timing_err   <= 1'b0;
      line_seen_q  <= 1'b0;
      ref_valid_q  <= 1'b0;
      ref_len_q    <= '0;
      frame_seen_q <= 1'b0;
      flen_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      hsync_o      <= hsync_in;
      vsync_o      <= vsync_in;
      hblnk_o      <= hblnk_in;
      vblnk_o      <= vblnk_in;
      hcount       <= hcount_d;
      vcount       <= vcount_d;
      line_len     <= line_len_d;
      frame_lines  <= frame_lines_d;
      locked       <= locked_d;
      timing_err   <= err;
      line_seen_q  <= line_seen_d;
      ref_valid_q  <= ref_valid_d;
      ref_len_q    <= ref_len_d;
      frame_seen_q <= frame_seen_d;
      flen_valid_q <= flen_valid_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

endmodule
